// File: rtl/ext_pkg.sv
// Shared definitions for the buffered immediate extender.
// Holds the extension op codes, the op field width and ext_calc().
// ext_calc() is the single source of truth for immediate generation.
// The pipe, decode-side checks and reference models all use it.
package ext_pkg;

  localparam int unsigned OP_W      = 3;
  localparam int unsigned EXT_DIN_W = 26;
  localparam int unsigned MAX_XLEN  = 64;

  localparam logic [OP_W-1:0] EXT_20   = 3'd0;
  localparam logic [OP_W-1:0] EXT_12   = 3'd1;
  localparam logic [OP_W-1:0] EXT_5    = 3'd2;
  localparam logic [OP_W-1:0] EXT_12U  = 3'd3;
  localparam logic [OP_W-1:0] EXT_16S2 = 3'd4;
  localparam logic [OP_W-1:0] EXT_26S2 = 3'd5;
  localparam logic [OP_W-1:0] EXT_14S2 = 3'd6;
  localparam logic [OP_W-1:0] EXT_RAW  = 3'd7;

  // The result is always extended to MAX_XLEN. A narrower consumer truncates it,
  // and the truncated value is still correctly sign- or zero-extended.
  function automatic logic [MAX_XLEN-1:0] ext_calc(input logic [EXT_DIN_W-1:0] din,
                                                   input logic [OP_W-1:0]      op);
    logic [MAX_XLEN-1:0] res;
    case (op)
      EXT_20:   res = {{32{din[24]}}, din[24:5], 12'h000};
      EXT_12:   res = {{52{din[21]}}, din[21:10]};
      EXT_5:    res = {59'd0, din[14:10]};
      EXT_12U:  res = {52'd0, din[21:10]};
      EXT_16S2: res = {{46{din[25]}}, din[25:10], 2'b00};
      EXT_26S2: res = {{36{din[9]}}, din[9:0], din[25:10], 2'b00};
      EXT_14S2: res = {{48{din[23]}}, din[23:10], 2'b00};
      default:  res = {38'd0, din};  // EXT_RAW
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ext_pipe_if.sv
// Handshake bundle for ext_pipe. It carries flush, the request channel,
// the result channel and the occupancy count.
// master: the request producer / result consumer side.
// slave:  the ext_pipe side.
interface ext_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DIN_W = 26,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned DEPTH = 2
);
  import ext_pkg::*;

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DIN_W-1:0]  in_din;
  logic [OP_W-1:0]   in_op;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_ext;
  logic [TAG_W-1:0]  out_tag;
  logic [CntW-1:0]   count;

  modport master (
    output flush, in_valid, in_din, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_ext, out_tag, count
  );

  modport slave (
    input  flush, in_valid, in_din, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_ext, out_tag, count
  );

endinterface

// File: rtl/ext_fifo.sv
// Generic in-order FIFO of Depth entries, each Width bits wide.
// Ports:
//   clk_i, rst_ni          clock and asynchronous active-low reset
//   flush_i                synchronous clear; it discards a push or pop in the same cycle
//   push_i, wdata_i        write request and its data (ignored when full)
//   pop_i                  read request (ignored when empty)
//   rdata_o                head entry
//   full_o, empty_o        occupancy flags, derived only from registered state
//   count_o                occupancy
module ext_fifo #(
  parameter int unsigned Width = 40,
  parameter int unsigned Depth = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push, pop;

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign push    = push_i & ~full_o;
  assign pop     = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Depth is a power of two, so the natural pointer overflow wraps modulo Depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/ext_pipe.sv
// Buffered immediate extender that sits between decode and issue.
// Each accepted request is extended by ext_calc() at the write side.
// The result and its tag are stored in an in-order FIFO. The output channel
// is driven only from FIFO storage, so no path runs from in_* to out_*.
// Ports:
//   cpu_clk, cpu_rstn  clock and asynchronous active-low reset
//   bus (slave)        flush, in_valid/in_ready/in_din/in_op/in_tag,
//                      out_valid/out_ready/out_ext/out_tag, count
module ext_pipe
  import ext_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DIN_W = 26,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 8
) (
  input  logic        cpu_clk,
  input  logic        cpu_rstn,
  ext_pipe_if.slave   bus
);

  localparam int unsigned EntW = XLEN + TAG_W;

  logic [DIN_W-1:0] din;
  logic [EntW-1:0]  wdata;
  logic [EntW-1:0]  rdata;
  logic             full, empty;
  logic             fire_in, fire_out;

  assign din = bus.in_din;

  // Only the extended value is stored. The raw field and the op are not kept.
  assign wdata = {XLEN'(ext_calc(din, bus.in_op)), bus.in_tag};

  // in_ready comes from registered occupancy only. A full FIFO refuses input
  // even when a pop happens in the same cycle.
  assign bus.in_ready  = ~full;
  assign bus.out_valid = ~empty;
  assign fire_in       = bus.in_valid & ~full;
  assign fire_out      = ~empty & bus.out_ready;

  assign bus.out_ext = rdata[EntW-1:TAG_W];
  assign bus.out_tag = rdata[TAG_W-1:0];

  ext_fifo #(
    .Width (EntW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (cpu_clk),
    .rst_ni  (cpu_rstn),
    .flush_i (bus.flush),
    .push_i  (fire_in),
    .wdata_i (wdata),
    .pop_i   (fire_out),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty),
    .count_o (bus.count)
  );

endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe. It drives a 32-bit and a 64-bit instance.
module tb_ext_pipe;
  import ext_pkg::*;

  logic cpu_clk = 1'b0;
  logic cpu_rstn;
  int   errors = 0;
  int   checks = 0;

  always #5 cpu_clk = ~cpu_clk;

  ext_pipe_if #(.XLEN(32), .DIN_W(26), .TAG_W(8), .DEPTH(2)) b32 ();
  ext_pipe_if #(.XLEN(64), .DIN_W(26), .TAG_W(8), .DEPTH(2)) b64 ();

  ext_pipe #(.XLEN(32), .DIN_W(26), .DEPTH(2), .TAG_W(8)) u_dut32 (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .bus      (b32.slave)
  );

  ext_pipe #(.XLEN(64), .DIN_W(26), .DEPTH(2), .TAG_W(8)) u_dut64 (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .bus      (b64.slave)
  );

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic idle();
    b32.flush = 0; b32.in_valid = 0; b32.in_din = '0; b32.in_op = '0;
    b32.in_tag = '0; b32.out_ready = 0;
    b64.flush = 0; b64.in_valid = 0; b64.in_din = '0; b64.in_op = '0;
    b64.in_tag = '0; b64.out_ready = 0;
  endtask

  // Drives a request whose ext result equals the tag (EXT_RAW on din = tag).
  task automatic drive_raw(input logic [7:0] tag);
    b32.in_valid = 1;
    b32.in_op    = EXT_RAW;
    b32.in_din   = {18'd0, tag};
    b32.in_tag   = tag;
  endtask

  task automatic test_reset();
    cpu_rstn = 0;
    idle();
    #12;
    checks++; if (b32.count !== 2'd0) begin errors++;
      $display("FAIL reset_count: got %0d want 0", b32.count); end
    checks++; if (b32.out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid: got %b want 0", b32.out_valid); end
    checks++; if (b32.out_ext !== 32'h0) begin errors++;
      $display("FAIL reset_out_ext: got %h want 0", b32.out_ext); end
    checks++; if (b32.out_tag !== 8'h0) begin errors++;
      $display("FAIL reset_out_tag: got %h want 0", b32.out_tag); end
    cpu_rstn = 1;
    #1;
    checks++; if (b32.in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_in_ready: got %b want 1", b32.in_ready); end
    tick();
  endtask

  task automatic test_single();
    b32.in_valid = 1; b32.in_din = 26'h3FFFC00; b32.in_op = EXT_12;
    b32.in_tag = 8'h5A; b32.out_ready = 1;
    tick();
    b32.in_valid = 0;
    checks++; if (b32.out_valid !== 1'b1) begin errors++;
      $display("FAIL single_valid: got %b want 1", b32.out_valid); end
    checks++; if (b32.out_ext !== 32'hFFFFFFFF) begin errors++;
      $display("FAIL single_ext: got %h want ffffffff", b32.out_ext); end
    checks++; if (b32.out_tag !== 8'h5A) begin errors++;
      $display("FAIL single_tag: got %h want 5a", b32.out_tag); end
    tick();
    checks++; if (b32.count !== 2'd0) begin errors++;
      $display("FAIL single_count_after_pop: got %0d want 0", b32.count); end
  endtask

  task automatic test_sweep32();
    logic [25:0] din_v [6];
    logic [2:0]  op_v  [6];
    logic [31:0] exp_v [6];
    din_v[0] = 26'h02468A0; op_v[0] = EXT_20;   exp_v[0] = 32'h12345000;
    din_v[1] = 26'h3FFFFFF; op_v[1] = EXT_5;    exp_v[1] = 32'h0000001F;
    din_v[2] = 26'h3FFFFFF; op_v[2] = EXT_12U;  exp_v[2] = 32'h00000FFF;
    din_v[3] = 26'h00003FF; op_v[3] = EXT_26S2; exp_v[3] = 32'hFFFC0000;
    din_v[4] = 26'h3FFFFFF; op_v[4] = EXT_RAW;  exp_v[4] = 32'h03FFFFFF;
    din_v[5] = 26'h2000400; op_v[5] = EXT_16S2; exp_v[5] = 32'hFFFE0004;
    b32.out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      b32.in_valid = 1; b32.in_din = din_v[i]; b32.in_op = op_v[i];
      b32.in_tag = 8'(i + 8'h20);
      tick();
      b32.in_valid = 0;
      checks++; if (b32.out_ext !== exp_v[i] || b32.out_tag !== 8'(i + 8'h20)) begin
        errors++;
        $display("FAIL sweep32[%0d]: got %h/%h want %h/%h", i, b32.out_ext, b32.out_tag,
                 exp_v[i], 8'(i + 8'h20));
      end
      tick();
    end
  endtask

  task automatic test_sweep64();
    logic [25:0] din_v [3];
    logic [2:0]  op_v  [3];
    logic [63:0] exp_v [3];
    din_v[0] = 26'h3FFFC00; op_v[0] = EXT_12;   exp_v[0] = 64'hFFFFFFFFFFFFFFFF;
    din_v[1] = 26'h3FFFFFF; op_v[1] = EXT_5;    exp_v[1] = 64'h000000000000001F;
    din_v[2] = 26'h00003FF; op_v[2] = EXT_26S2; exp_v[2] = 64'hFFFFFFFFFFFC0000;
    b64.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      b64.in_valid = 1; b64.in_din = din_v[i]; b64.in_op = op_v[i];
      b64.in_tag = 8'(i + 8'h40);
      tick();
      b64.in_valid = 0;
      checks++; if (b64.out_ext !== exp_v[i] || b64.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL sweep64[%0d]: got %h valid %b want %h valid 1", i, b64.out_ext,
                 b64.out_valid, exp_v[i]);
      end
      tick();
    end
    b64.out_ready = 0;
  endtask

  task automatic test_backpressure();
    b32.out_ready = 0;
    drive_raw(8'hA1); tick();
    drive_raw(8'hA2); tick();
    checks++; if (b32.count !== 2'd2 || b32.in_ready !== 1'b0) begin errors++;
      $display("FAIL bp_full: count %0d in_ready %b want 2/0", b32.count, b32.in_ready); end
    drive_raw(8'hA3); tick();
    checks++; if (b32.count !== 2'd2) begin errors++;
      $display("FAIL bp_held_count: got %0d want 2", b32.count); end
    checks++; if (b32.out_tag !== 8'hA1 || b32.out_ext !== 32'hA1) begin errors++;
      $display("FAIL bp_head_stable: got %h/%h want a1/a1", b32.out_tag, b32.out_ext); end
    b32.out_ready = 1;
    #1;
    checks++; if (b32.in_ready !== 1'b0) begin errors++;
      $display("FAIL bp_ready_indep: got %b want 0", b32.in_ready); end
    tick();
    checks++; if (b32.count !== 2'd1 || b32.out_tag !== 8'hA2) begin errors++;
      $display("FAIL bp_drain1: count %0d tag %h want 1/a2", b32.count, b32.out_tag); end
    tick();
    b32.in_valid = 0;
    checks++; if (b32.count !== 2'd1 || b32.out_tag !== 8'hA3) begin errors++;
      $display("FAIL bp_drain2: count %0d tag %h want 1/a3", b32.count, b32.out_tag); end
    tick();
    checks++; if (b32.count !== 2'd0 || b32.out_valid !== 1'b0) begin errors++;
      $display("FAIL bp_empty: count %0d valid %b want 0/0", b32.count, b32.out_valid); end
  endtask

  task automatic test_full_pop();
    b32.out_ready = 0;
    drive_raw(8'hB1); tick();
    drive_raw(8'hB2); tick();
    drive_raw(8'hB3); b32.out_ready = 1;
    #1;
    checks++; if (b32.in_ready !== 1'b0) begin errors++;
      $display("FAIL fullpop_ready: got %b want 0", b32.in_ready); end
    tick();
    b32.in_valid = 0;
    checks++; if (b32.count !== 2'd1 || b32.out_tag !== 8'hB2) begin errors++;
      $display("FAIL fullpop_count: count %0d tag %h want 1/b2", b32.count, b32.out_tag); end
    tick();
    checks++; if (b32.count !== 2'd0 || b32.out_valid !== 1'b0) begin errors++;
      $display("FAIL fullpop_refused: count %0d valid %b want 0/0", b32.count,
               b32.out_valid); end
  endtask

  task automatic test_wrap();
    logic [7:0] q [$];
    int sent = 0;
    int got  = 0;
    bit do_push, do_pop;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      if (sent < 10) drive_raw(8'(8'h30 + sent));
      else b32.in_valid = 0;
      b32.out_ready = (cyc % 2 == 0);
      #1;
      checks++; if (b32.count !== 2'(q.size())) begin errors++;
        $display("FAIL wrap_count@%0d: got %0d want %0d", cyc, b32.count, q.size()); end
      checks++; if (b32.in_ready !== (q.size() != 2)) begin errors++;
        $display("FAIL wrap_ready@%0d: got %b want %b", cyc, b32.in_ready, q.size() != 2); end
      do_push = b32.in_valid && (q.size() != 2);
      do_pop  = b32.out_ready && (q.size() != 0);
      if (do_pop) begin
        checks++;
        if (b32.out_valid !== 1'b1 || b32.out_tag !== q[0] || b32.out_ext !== {24'd0, q[0]})
        begin
          errors++;
          $display("FAIL wrap_order@%0d: got %b/%h/%h want 1/%h", cyc, b32.out_valid,
                   b32.out_tag, b32.out_ext, q[0]);
        end
      end
      tick();
      if (do_pop) begin void'(q.pop_front()); got++; end
      if (do_push) begin q.push_back(8'(8'h30 + sent)); sent++; end
    end
    b32.in_valid = 0;
    checks++; if (got != 10 || q.size() != 0) begin errors++;
      $display("FAIL wrap_total: got %0d outstanding %0d want 10/0", got, q.size()); end
    b32.out_ready = 0;
  endtask

  task automatic test_flush();
    b32.out_ready = 0;
    drive_raw(8'hC1); tick();
    drive_raw(8'hC2); tick();
    checks++; if (b32.count !== 2'd2) begin errors++;
      $display("FAIL flush_pre: got %0d want 2", b32.count); end
    b32.flush = 1; drive_raw(8'hC3); b32.out_ready = 1;
    tick();
    b32.flush = 0; b32.in_valid = 0;
    checks++; if (b32.count !== 2'd0 || b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1)
    begin errors++;
      $display("FAIL flush_clear: count %0d valid %b ready %b want 0/0/1", b32.count,
               b32.out_valid, b32.in_ready); end
    tick();
    checks++; if (b32.count !== 2'd0) begin errors++;
      $display("FAIL flush_dropped: got %0d want 0", b32.count); end
    drive_raw(8'hC4); tick();
    b32.in_valid = 0;
    checks++; if (b32.out_valid !== 1'b1 || b32.out_tag !== 8'hC4) begin errors++;
      $display("FAIL flush_resume: valid %b tag %h want 1/c4", b32.out_valid, b32.out_tag); end
    tick();
    b32.out_ready = 0;
  endtask

  task automatic test_reset_mid();
    b32.out_ready = 0;
    drive_raw(8'hD1); tick();
    drive_raw(8'hD2); tick();
    drive_raw(8'hD3);
    #3;
    cpu_rstn = 0;
    #1;
    checks++; if (b32.out_valid !== 1'b0 || b32.count !== 2'd0) begin errors++;
      $display("FAIL rstmid_state: valid %b count %0d want 0/0", b32.out_valid, b32.count); end
    checks++; if (b32.out_ext !== 32'h0 || b32.out_tag !== 8'h0) begin errors++;
      $display("FAIL rstmid_data: ext %h tag %h want 0/0", b32.out_ext, b32.out_tag); end
    #1;
    b32.in_valid = 0;
    cpu_rstn = 1;
    tick();
    checks++; if (b32.count !== 2'd0 || b32.in_ready !== 1'b1) begin errors++;
      $display("FAIL rstmid_after: count %0d ready %b want 0/1", b32.count, b32.in_ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep32();
    test_sweep64();
    test_backpressure();
    test_full_pop();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
